// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: runs one convolution layer by reusing a single
// conv_module across NUM_FILTERS binary filters.
//   start/in_data/filter_bank : layer request, sampled on an accepted start
//   conv_start/conv_in/conv_filter/conv_out/conv_end : conv_module handshake
//   filt_idx/result/busy/done/result_valid/error : layer progress and status
module conv_layer_sequencer #(
    parameter int NUM_FILTERS = 4,
    parameter int IN_W        = 576,
    parameter int FILT_W      = 25,
    parameter int OUT_W       = 64,
    parameter int TIMEOUT     = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [IN_W-1:0]              in_data,
    input  logic [NUM_FILTERS*FILT_W-1:0] filter_bank,
    output logic                         conv_start,
    output logic [IN_W-1:0]              conv_in,
    output logic [FILT_W-1:0]            conv_filter,
    input  logic [OUT_W-1:0]             conv_out,
    input  logic                         conv_end,
    output logic [3:0]                   filt_idx,
    output logic [NUM_FILTERS*OUT_W-1:0] result,
    output logic                         busy,
    output logic                         done,
    output logic                         result_valid,
    output logic                         error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0]    LAST_IDX = 4'(NUM_FILTERS - 1);
    // Counter holds 0 in the first WAIT cycle, so the abort edge closes
    // the TIMEOUT-th WAIT cycle.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]                    state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [3:0]                    filt_idx_q, filt_idx_d;
    logic                          conv_start_q, conv_start_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          result_valid_q, result_valid_d;
    logic                          error_q, error_d;
    logic [NUM_FILTERS*OUT_W-1:0]  result_q, result_d;
    logic [IN_W-1:0]               in_q, in_d;
    logic [NUM_FILTERS*FILT_W-1:0] bank_q, bank_d;
    logic [FILT_W-1:0]             conv_filter_q, conv_filter_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        filt_idx_d     = filt_idx_q;
        result_valid_d = result_valid_q;
        error_d        = error_q;
        result_d       = result_q;
        in_d           = in_q;
        bank_d         = bank_q;
        conv_filter_d  = conv_filter_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_d           = in_data;
                    bank_d         = filter_bank;
                    result_valid_d = 1'b0;
                    error_d        = 1'b0;
                    filt_idx_d     = 4'd0;
                    conv_filter_d  = filter_bank[FILT_W-1:0];
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A conv_end on the timeout edge still counts as a result.
                if (conv_end) begin
                    result_d[32'(filt_idx_q)*OUT_W +: OUT_W] = conv_out;
                    if (filt_idx_q == LAST_IDX) begin
                        result_valid_d = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        filt_idx_d    = filt_idx_q + 4'd1;
                        conv_filter_d = bank_q[32'(filt_idx_d)*FILT_W +: FILT_W];
                        state_d       = S_LAUNCH;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state.
        conv_start_d = (state_d == S_LAUNCH);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            filt_idx_q     <= 4'd0;
            conv_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            result_q       <= '0;
            in_q           <= '0;
            bank_q         <= '0;
            conv_filter_q  <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            filt_idx_q     <= filt_idx_d;
            conv_start_q   <= conv_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_valid_q <= result_valid_d;
            error_q        <= error_d;
            result_q       <= result_d;
            in_q           <= in_d;
            bank_q         <= bank_d;
            conv_filter_q  <= conv_filter_d;
        end
    end

    assign conv_start   = conv_start_q;
    assign conv_in      = in_q;
    assign conv_filter  = conv_filter_q;
    assign filt_idx     = filt_idx_q;
    assign result       = result_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result_valid = result_valid_q;
    assign error        = error_q;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// tb_conv_layer_sequencer: scoreboard bench for conv_layer_sequencer with
// a behavioural conv_module model of programmable per-filter latency.
module tb_conv_layer_sequencer;

    localparam int NF = 4;
    localparam int IW = 576;
    localparam int FW = 25;
    localparam int OW = 64;
    localparam int TO = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             start;
    logic [IW-1:0]    in_data;
    logic [NF*FW-1:0] filter_bank;
    logic             conv_start;
    logic [IW-1:0]    conv_in;
    logic [FW-1:0]    conv_filter;
    logic [OW-1:0]    conv_out = '0;
    logic             conv_end = 1'b0;
    logic [3:0]       filt_idx;
    logic [NF*OW-1:0] result;
    logic             busy, done, result_valid, error;

    conv_layer_sequencer #(.NUM_FILTERS(NF), .TIMEOUT(TO)) u0 (
        .clk(clk), .reset(reset), .start(start), .in_data(in_data),
        .filter_bank(filter_bank), .conv_start(conv_start),
        .conv_in(conv_in), .conv_filter(conv_filter),
        .conv_out(conv_out), .conv_end(conv_end), .filt_idx(filt_idx),
        .result(result), .busy(busy), .done(done),
        .result_valid(result_valid), .error(error)
    );

    logic          start1 = 1'b0;
    logic [IW-1:0] in_data1 = '0;
    logic [FW-1:0] filter_bank1 = '0;
    logic          conv_start1;
    logic [IW-1:0] conv_in1;
    logic [FW-1:0] conv_filter1;
    logic [OW-1:0] conv_out1 = '0;
    logic          conv_end1 = 1'b0;
    logic [3:0]    filt_idx1;
    logic [OW-1:0] result1;
    logic          busy1, done1, result_valid1, error1;

    conv_layer_sequencer #(.NUM_FILTERS(1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .in_data(in_data1),
        .filter_bank(filter_bank1), .conv_start(conv_start1),
        .conv_in(conv_in1), .conv_filter(conv_filter1),
        .conv_out(conv_out1), .conv_end(conv_end1), .filt_idx(filt_idx1),
        .result(result1), .busy(busy1), .done(done1),
        .result_valid(result_valid1), .error(error1)
    );

    int pass_n = 0;
    int total_n = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail_now(input string nm);
        total_n++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // conv_module model: answers {60'h0, filter[3:0]} lat[i] cycles after
    // the launch of filter i, or never when i == drop_idx.
    int          lat [NF];
    int          drop_idx = -1;
    int          launch_base = 0;
    int          total_launch = 0;
    int          cd = 0;
    bit          drop_cur = 1'b0;
    logic [3:0]  fval = '0;
    int          stray_req = 0;
    int          stray_ack = 0;

    always @(negedge clk) begin
        int idx;
        conv_end = 1'b0;
        if (reset) cd = 0;
        else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !drop_cur) begin
                    conv_end = 1'b1;
                    conv_out = {60'h0, fval};
                end
            end
            if (conv_start) begin
                idx = total_launch - launch_base;
                drop_cur = (idx == drop_idx);
                cd = lat[idx % NF];
                fval = conv_filter[3:0];
                total_launch++;
            end
            if (stray_req != stray_ack) begin
                conv_end = 1'b1;
                conv_out = '1;
                stray_ack = stray_req;
            end
        end
    end

    typedef struct {
        bit               err;
        logic [NF*OW-1:0] res;
    } exp_t;
    exp_t sbq [$];
    logic err_prev = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) err_prev = 1'b0;
        else begin
            if (done || (error && !err_prev)) begin
                if (sbq.size() == 0) begin
                    total_n++;
                    $display("FAIL sb_unexpected: done=%0b error=%0b", done, error);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_outcome_err", 256'(error && !done), 256'(e.err));
                    chk("sb_result", 256'(result), 256'(e.res));
                    chk("sb_valid", 256'(result_valid), 256'(!e.err));
                end
            end
            err_prev = error;
        end
    end

    int starts1 = 0;
    always @(negedge clk) if (conv_start1) starts1++;

    logic [FW-1:0]    filt [NF];
    logic [NF*OW-1:0] model_buf = '0;

    task automatic run_layer(input int drop, input bit inject, input bit abort);
        logic [IW-1:0]    data;
        logic [NF*OW-1:0] exp_res;
        exp_t e;
        int n, k, last, n_exp;
        for (int i = 0; i < IW / 32; i++) data[i*32 +: 32] = $urandom();
        exp_res = model_buf;
        for (int i = 0; i < NF; i++)
            if (drop < 0 || i < drop)
                exp_res[i*OW +: OW] = {60'h0, filt[i][3:0]};
        @(negedge clk);
        for (int i = 0; i < NF; i++) filter_bank[i*FW +: FW] = filt[i];
        in_data = data;
        launch_base = total_launch;
        drop_idx = drop;
        start = 1'b1;
        if (!abort) begin
            e.err = (drop >= 0);
            e.res = exp_res;
            sbq.push_back(e);
            model_buf = exp_res;
        end
        @(negedge clk);
        start = 1'b0;
        n = 1; k = 0; last = 0;
        chk("launch_latency", 256'(conv_start), 256'(1));
        chk("error_cleared", 256'(error), 256'(0));
        chk("valid_cleared", 256'(result_valid), 256'(0));
        forever begin
            if (conv_start) begin
                chk("filt_idx", 256'(filt_idx), 256'(k));
                chk("conv_filter", 256'(conv_filter), 256'(filt[k % NF]));
                chk("conv_in", 256'(conv_in), 256'(data));
                if (k > 0)
                    chk("launch_spacing", 256'(n - last), 256'(lat[(k-1) % NF] + 1));
                last = n;
                k++;
            end
            if (done || error) break;
            if (inject && n == 4) begin
                start = 1'b1;
                in_data = ~data;
            end
            if (inject && n == 5) start = 1'b0;
            if (abort && k == 3 && n == last + 3) begin
                reset = 1'b1;
                @(negedge clk);
                chk("abort_busy", 256'(busy), 256'(0));
                chk("abort_conv_start", 256'(conv_start), 256'(0));
                chk("abort_done_err", 256'({done, error}), 256'(0));
                chk("abort_filt_idx", 256'(filt_idx), 256'(0));
                chk("abort_result", 256'(result), 256'(0));
                reset = 1'b0;
                stray_req++;
                repeat (3) @(negedge clk);
                chk("stray_busy", 256'(busy), 256'(0));
                chk("stray_conv_start", 256'(conv_start), 256'(0));
                chk("stray_result", 256'(result), 256'(0));
                model_buf = '0;
                return;
            end
            if (n > 20000) begin
                fail_now("layer_wait");
                return;
            end
            @(negedge clk);
            n++;
        end
        if (drop < 0) begin
            n_exp = 1;
            for (int i = 0; i < NF; i++) n_exp += lat[i] + 1;
            chk("done_cycle", 256'(n), 256'(n_exp));
            chk("launch_count", 256'(k), 256'(NF));
            chk("done_valid", 256'(result_valid), 256'(1));
            chk("done_no_error", 256'(error), 256'(0));
            if (inject) begin
                start = 1'b1;
                in_data = ~data;
            end
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_done", 256'(busy), 256'(0));
            chk("no_relaunch", 256'(conv_start), 256'(0));
            chk("done_pulse_width", 256'(done), 256'(0));
            chk("conv_in_held", 256'(conv_in), 256'(data));
            chk("valid_holds", 256'(result_valid), 256'(1));
        end else begin
            chk("timeout_cycle", 256'(n), 256'(last + TO + 1));
            chk("timeout_launches", 256'(k), 256'(drop + 1));
            chk("timeout_busy", 256'(busy), 256'(0));
            chk("timeout_valid", 256'(result_valid), 256'(0));
            chk("timeout_no_done", 256'(done), 256'(0));
        end
    endtask

    initial begin
        logic [OW-1:0] v;
        reset = 1'b1;
        start = 1'b0;
        in_data = '0;
        filter_bank = '0;
        for (int i = 0; i < NF; i++) lat[i] = 12;
        repeat (3) @(negedge clk);
        chk("rst_status", 256'({busy, done, error, result_valid, conv_start}), 256'(0));
        chk("rst_filt_idx", 256'(filt_idx), 256'(0));
        chk("rst_result", 256'(result), 256'(0));
        chk("rst_conv_in", 256'(conv_in), 256'(0));
        chk("rst_conv_filter", 256'(conv_filter), 256'(0));
        chk("rst_nf1", 256'({busy1, done1, error1, result1}), 256'(0));
        reset = 1'b0;

        for (int i = 0; i < NF; i++) filt[i] = FW'(i + 1);
        run_layer(-1, 1'b0, 1'b0);
        chk("basic_result", 256'(result), {64'h4, 64'h3, 64'h2, 64'h1});

        for (int i = 0; i < NF; i++) filt[i] = FW'($urandom());
        run_layer(-1, 1'b1, 1'b0);

        for (int i = 0; i < NF; i++) filt[i] = FW'(i + 1);
        run_layer(1, 1'b0, 1'b0);
        chk("timeout_slot0", 256'(result[OW-1:0]), 256'(64'h1));
        chk("timeout_error", 256'(error), 256'(1));

        for (int i = 0; i < NF; i++) filt[i] = FW'($urandom());
        run_layer(-1, 1'b0, 1'b0);

        lat[2] = TO;
        for (int i = 0; i < NF; i++) filt[i] = FW'($urandom());
        run_layer(-1, 1'b0, 1'b0);
        lat[2] = 12;

        run_layer(-1, 1'b0, 1'b1);

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < NF; i++) begin
                filt[i] = FW'($urandom());
                lat[i] = $urandom_range(1, 20);
            end
            run_layer(-1, 1'b0, 1'b0);
        end

        @(negedge clk);
        filter_bank1 = 25'h1abcde;
        in_data1 = {IW{1'b1}};
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("nf1_launch", 256'(conv_start1), 256'(1));
        chk("nf1_filter", 256'(conv_filter1), 256'(25'h1abcde));
        repeat (4) @(negedge clk);
        v = {$urandom(), $urandom()};
        conv_out1 = v;
        conv_end1 = 1'b1;
        @(negedge clk);
        conv_end1 = 1'b0;
        chk("nf1_done", 256'(done1), 256'(1));
        chk("nf1_result", 256'(result1), 256'(v));
        chk("nf1_valid", 256'(result_valid1), 256'(1));
        chk("nf1_launches", 256'(starts1), 256'(1));
        @(negedge clk);
        chk("nf1_idle", 256'(busy1), 256'(0));

        repeat (4) @(negedge clk);
        chk("sb_drained", 256'(sbq.size()), 256'(0));
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
